maxpool_2x2: RTL and testbench
==============================

Name: maxpool_2x2

Overview:
- Downstream consumer of the convolution stage. Accepts its 32-bit row-major output stream of an M x M feature map.
- Applies requantization (arithmetic shift plus saturation to signed 16 bit), optional ReLU, and 2x2 max-pooling with stride 2.
- Emits a (M/2) x (M/2) signed 16-bit stream in the same pixel format the convolution stage takes as input, so layers can be chained.

Parameters:
- M, 28: input feature-map width and height (pixels per row, rows per frame).
- ACC_W, 32: input pixel width (convolution accumulator width).
- PIX_W, 16: output pixel width.
- Q_SHIFT, 8: arithmetic right shift applied to each input before saturation, range 0..ACC_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_pxl  in  ACC_W  signed convolution output pixel.
- i_data_valid  in  1  i_pxl valid this cycle; may drop for any number of cycles (bubbles).
- o_pxl  out  PIX_W  signed pooled pixel.
- o_data_valid  out  1  o_pxl valid; single-cycle qualifier per output.
- o_count  out  $clog2((M/2)*(M/2))+1  index of the current output within the frame.
- o_frame_done  out  1  one-cycle pulse together with the last output of a frame.

Behaviour:
- Reset (synchronous, active-high) sets the following to 0:
  - o_pxl, o_data_valid, o_count, o_frame_done;
  - column and row counters, pair register, line buffer.
  - The FSM goes to EVEN_ROW.
- Only cycles with i_data_valid=1 advance state. Bubbles hold all state and drive o_data_valid=0.
- Per-pixel preprocessing (combinational on accepted input):
  - q = i_pxl >>> Q_SHIFT;
  - saturate q to [-2^(PIX_W-1), 2^(PIX_W-1)-1];
  - apply ReLU if enabled (see Optional Feature).
- Counters:
  - col runs 0..M-1; at M-1 it wraps to 0 and row increments.
  - row runs 0..M-1; at M-1 it wraps to 0 (end of frame).
- FSM states:
  - EVEN_ROW (row even):
    - even col: store the value in the pair register.
    - odd col: write max(pair, value) into line_buf[col>>1].
    - At the end of the row, go to ODD_ROW.
  - ODD_ROW (row odd):
    - even col: store the value in the pair register.
    - odd col: o_pxl <= max(pair, value, line_buf[col>>1]); o_data_valid <= 1; o_count increments.
    - At the end of the row, go to EVEN_ROW.
- Latency: an output is registered one cycle after the accepted bottom-right pixel of its 2x2 window.
- Odd M: the last column (col=M-1 when M is odd) and the last row are accepted but ignored (floor pooling). Counters still wrap at M.
- Comparisons are signed, 16 bit. On ties either operand may be chosen; the value is identical.
- o_frame_done=1 in the same cycle as output index (M/2)^2-1. o_count returns to 0 on the next output.
- Back-to-back frames need no gap cycles: row 0 of the next frame may follow row M-1 immediately.
- reset mid-frame discards the partial frame. The next accepted pixel is treated as (row 0, col 0).
- line_buf holds M/2 entries of PIX_W bits. Each entry is written in an even row before it is read in the following odd row, so no bypass is needed.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- Defined: the preprocessed value is max(sat_q, 0), so the output is never negative.
- Undefined: no ReLU; signed max-pooling of the saturated values, and negative outputs are legal.

Decomposition:
- Package cnn_pkg holds:
  - constants ACC_W=32 and PIX_W=16;
  - a typedef for a signed pixel;
  - function sat_shift(acc, shift) returning a saturated PIX_W value, for reuse by later layers.
- One sub-module, pool_line_buf: depth M/2, width PIX_W, one synchronous write port and one combinational read port, addressed by col>>1.

Test Plan:
- Ramp: M=4, Q_SHIFT=0, i_pxl=0..15 continuous valid. Outputs are 5, 7, 13, 15, each one cycle after inputs 5, 7, 13, 15; o_frame_done pulses with 15; o_count goes 0..3.
- Bubbles: same ramp with i_data_valid toggling 1,0,1,0. Outputs are identical (5, 7, 13, 15); o_data_valid is never high during a bubble cycle.
- Saturation and shift: M=4, Q_SHIFT=8, all inputs 0x7FFF_FF00 gives all outputs 32767; all inputs 0xFFFF_FE00 (-512) gives -2 without MAXPOOL_RELU_EN and 0 with it.
- Reset mid-frame: M=4 ramp, reset asserted after 6 pixels, then a fresh 0..15 ramp. All outputs are 0 during reset, then 5, 7, 13, 15 with no stale line_buf data.
- Back-to-back frames and odd M:
  - Two consecutive M=4 frames give 8 outputs and two o_frame_done pulses.
  - M=5 ramp 0..24 gives outputs 6, 8, 16, 18; col 4 and row 4 are ignored; o_frame_done pulses with 18.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and the requantization helper reused by the layers
// that consume convolution accumulators.
package cnn_pkg;

    localparam int ACC_W = 32;
    localparam int PIX_W = 16;

    typedef logic signed [PIX_W-1:0] pixel_t;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } pool_state_t;

    // Arithmetic shift, then clamp into the signed PIX_W range.
    function automatic pixel_t sat_shift(input logic signed [ACC_W-1:0] acc,
                                         input int unsigned shift);
        logic signed [ACC_W-1:0] q;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        q  = acc >>> shift;
        hi = {{(ACC_W-PIX_W+1){1'b0}}, {(PIX_W-1){1'b1}}};
        lo = {{(ACC_W-PIX_W+1){1'b1}}, {(PIX_W-1){1'b0}}};
        if (q > hi) begin
            sat_shift = hi[PIX_W-1:0];
        end else if (q < lo) begin
            sat_shift = lo[PIX_W-1:0];
        end else begin
            sat_shift = q[PIX_W-1:0];
        end
    endfunction

    function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
        pix_max = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of horizontal pair maxima: synchronous write, combinational
// read, cleared by reset.
module pool_line_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_2x2.sv
// Requantize a row-major M x M accumulator stream and 2x2/stride-2 max-pool it.
// Build option: define MAXPOOL_RELU_EN to clamp preprocessed pixels at zero.
module maxpool_2x2 #(
    parameter int          M       = 28,
    parameter int          ACC_W   = cnn_pkg::ACC_W,
    parameter int          PIX_W   = cnn_pkg::PIX_W,
    parameter int unsigned Q_SHIFT = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ACC_W-1:0]                i_pxl,
    input  logic                            i_data_valid,
    output logic [PIX_W-1:0]                o_pxl,
    output logic                            o_data_valid,
    output logic [$clog2((M/2)*(M/2)):0]    o_count,
    output logic                            o_frame_done
);

    import cnn_pkg::*;

    localparam int HALF  = M / 2;
    localparam int OUT_N = HALF * HALF;
    localparam int CW    = (M > 1) ? $clog2(M) : 1;
    localparam int AW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int NW    = $clog2(OUT_N) + 1;
    localparam logic [CW-1:0] LAST     = CW'(M - 1);
    localparam logic [NW-1:0] OUT_LAST = NW'(OUT_N - 1);
    localparam bit            ODD_M    = (M % 2) == 1;

    pool_state_t   state;
    pool_state_t   next_state;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [NW-1:0] out_idx;
    logic [AW-1:0] buf_addr;
    pixel_t        sat;
    pixel_t        pre;
    pixel_t        pair;
    pixel_t        pair_max;
    pixel_t        buf_rd;
    pixel_t        win_max;
    logic          row_end;
    logic          in_window;
    logic          buf_we;
    logic          pair_ld;
    logic          fire;

    assign sat = sat_shift(i_pxl, Q_SHIFT);

`ifdef MAXPOOL_RELU_EN
    assign pre = sat[PIX_W-1] ? '0 : sat;
`else
    assign pre = sat;
`endif

    // With odd M the trailing column and row are consumed but never pooled.
    assign row_end   = (col == LAST);
    assign in_window = !(ODD_M && (col == LAST || row == LAST));
    assign buf_addr  = AW'(col >> 1);
    assign pair_max  = pix_max(pair, pre);
    assign win_max   = pix_max(pair_max, buf_rd);

    pool_line_buf #(
        .DEPTH (HALF),
        .WIDTH (PIX_W),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we),
        .waddr (buf_addr),
        .wdata (pair_max),
        .raddr (buf_addr),
        .rdata (buf_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EVEN_ROW;
        end else begin
            state <= next_state;
        end
    end

    // The last row of a frame always returns to EVEN_ROW, even when M is odd.
    always_comb begin
        next_state = state;
        buf_we     = 1'b0;
        pair_ld    = 1'b0;
        fire       = 1'b0;
        if (i_data_valid) begin
            if (in_window) begin
                case (state)
                    EVEN_ROW: begin
                        pair_ld = !col[0];
                        buf_we  = col[0];
                    end
                    ODD_ROW: begin
                        pair_ld = !col[0];
                        fire    = col[0];
                    end
                    default: ;
                endcase
            end
            if (row_end) begin
                next_state = (row == LAST || state == ODD_ROW) ? EVEN_ROW : ODD_ROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col          <= '0;
            row          <= '0;
            pair         <= '0;
            out_idx      <= '0;
            o_pxl        <= '0;
            o_data_valid <= 1'b0;
            o_count      <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_data_valid) begin
                col <= row_end ? '0 : col + CW'(1);
                if (row_end) begin
                    row <= (row == LAST) ? '0 : row + CW'(1);
                end
                if (pair_ld) begin
                    pair <= pre;
                end
                if (fire) begin
                    o_pxl        <= win_max;
                    o_data_valid <= 1'b1;
                    o_count      <= out_idx;
                    o_frame_done <= (out_idx == OUT_LAST);
                    out_idx      <= (out_idx == OUT_LAST) ? '0 : out_idx + NW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Bench for maxpool_2x2: hand-derived vector table plus randomized frames
// checked against a frame-array reference model, over three configurations.
module tb_maxpool_2x2;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_pxl    [NDUT];
    logic        in_valid  [NDUT];
    logic [15:0] out_pxl   [NDUT];
    logic        out_valid [NDUT];
    logic [2:0]  out_cnt   [NDUT];
    logic        out_done  [NDUT];

    always #5 clk = ~clk;

    maxpool_2x2 #(.M(4), .Q_SHIFT(0)) dut_m4 (
        .clk(clk), .reset(reset), .i_pxl(in_pxl[0]), .i_data_valid(in_valid[0]),
        .o_pxl(out_pxl[0]), .o_data_valid(out_valid[0]), .o_count(out_cnt[0]),
        .o_frame_done(out_done[0])
    );

    maxpool_2x2 #(.M(4), .Q_SHIFT(8)) dut_m4_q8 (
        .clk(clk), .reset(reset), .i_pxl(in_pxl[1]), .i_data_valid(in_valid[1]),
        .o_pxl(out_pxl[1]), .o_data_valid(out_valid[1]), .o_count(out_cnt[1]),
        .o_frame_done(out_done[1])
    );

    maxpool_2x2 #(.M(5), .Q_SHIFT(0)) dut_m5 (
        .clk(clk), .reset(reset), .i_pxl(in_pxl[2]), .i_data_valid(in_valid[2]),
        .o_pxl(out_pxl[2]), .o_data_valid(out_valid[2]), .o_count(out_cnt[2]),
        .o_frame_done(out_done[2])
    );

    typedef struct {
        int d;
        bit rst;
        bit valid;
        int pxl;
        int cnt;
        bit done;
    } exp_t;

    typedef struct {
        int          d;
        bit          v;
        logic [31:0] p;
        bit          ev;
        int          epxl;
        int          ecnt;
        bit          edone;
    } vec_t;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_seen = 0;
    exp_t cur;
    int   pos   [NDUT];
    int   frame [NDUT][25];

    function automatic int dim(input int d);
        return (d == 2) ? 5 : 4;
    endfunction

    function automatic int shamt(input int d);
        return (d == 1) ? 8 : 0;
    endfunction

    function automatic int preprocess(input logic [31:0] p, input int sh);
        longint q;
        q = longint'($signed(p)) >>> sh;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`ifdef MAXPOOL_RELU_EN
        if (q < 0) q = 0;
`endif
        return int'(q);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (e > m) m = e;
        return m;
    endfunction

    // Pixel position in the frame decides everything: a window closes on
    // every odd-row/odd-col pixel that lies inside the floor-pooled area.
    task automatic model_accept(input int d, input logic [31:0] p);
        int m, h, r, c, a, idx;
        m = dim(d);
        h = m / 2;
        a = pos[d];
        r = a / m;
        c = a % m;
        frame[d][a] = preprocess(p, shamt(d));
        if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * h) && (c < 2 * h)) begin
            idx       = (r / 2) * h + c / 2;
            cur.valid = 1'b1;
            cur.pxl   = max4(frame[d][a], frame[d][a-1], frame[d][a-m], frame[d][a-m-1]);
            cur.cnt   = idx;
            cur.done  = (idx == h * h - 1);
        end
        pos[d] = (a + 1) % (m * m);
    endtask

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.rst) begin
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("dut%0d reset valid", d), int'(out_valid[d]), 0);
                check($sformatf("dut%0d reset pxl", d), int'(out_pxl[d]), 0);
                check($sformatf("dut%0d reset count", d), int'(out_cnt[d]), 0);
                check($sformatf("dut%0d reset frame_done", d), int'(out_done[d]), 0);
            end
        end else begin
            check($sformatf("dut%0d valid", e.d), int'(out_valid[e.d]), int'(e.valid));
            check($sformatf("dut%0d frame_done", e.d), int'(out_done[e.d]), int'(e.done));
            if (out_done[e.d]) done_seen++;
            if (e.valid) begin
                check($sformatf("dut%0d pxl", e.d), int'($signed(out_pxl[e.d])), e.pxl);
                check($sformatf("dut%0d count", e.d), int'(out_cnt[e.d]), e.cnt);
            end
        end
    endtask

    // Check what the previous edge produced, then present the next input.
    task automatic applyStimulus(input int d, input bit v, input logic [31:0] p);
        @(negedge clk);
        checkOutput(cur);
        for (int k = 0; k < NDUT; k++) in_valid[k] = 1'b0;
        in_valid[d] = v;
        in_pxl[d]   = p;
        cur.d     = d;
        cur.rst   = 1'b0;
        cur.valid = 1'b0;
        cur.pxl   = 0;
        cur.cnt   = 0;
        cur.done  = 1'b0;
        if (v) model_accept(d, p);
    endtask

    task automatic applyReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput(cur);
            reset = 1'b1;
            for (int k = 0; k < NDUT; k++) in_valid[k] = 1'b0;
            cur.d   = 0;
            cur.rst = 1'b1;
        end
        for (int k = 0; k < NDUT; k++) pos[k] = 0;
        @(negedge clk);
        checkOutput(cur);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input int d, input bit v, input logic [31:0] p,
                                input int hit, input int epxl);
        vec_t t;
        t.d     = d;
        t.v     = v;
        t.p     = p;
        t.ev    = v && (hit >= 0);
        t.epxl  = epxl;
        t.ecnt  = hit;
        t.edone = v && (hit == 3);
        return t;
    endfunction

    function automatic int hit4(input int i);
        case (i)
            5: return 0;
            7: return 1;
            13: return 2;
            15: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int hit5(input int i);
        case (i)
            6: return 0;
            8: return 1;
            16: return 2;
            18: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] rand_pixel();
        case ($urandom_range(0, 2))
            0: return $urandom;
            1: return 32'($urandom_range(0, 80000)) - 32'd40000;
            default: return 32'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tab[$];
        int   neg_exp;
`ifdef MAXPOOL_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -2;
`endif
        for (int i = 0; i < 16; i++) tab.push_back(mk(0, 1'b1, 32'(i), hit4(i), i));
        for (int i = 0; i < 16; i++) begin
            tab.push_back(mk(0, 1'b1, 32'(i), hit4(i), i));
            tab.push_back(mk(0, 1'b0, 32'hDEAD_BEEF, -1, 0));
        end
        for (int i = 0; i < 16; i++) tab.push_back(mk(1, 1'b1, 32'h7FFF_FF00, hit4(i), 32767));
        for (int i = 0; i < 16; i++) tab.push_back(mk(1, 1'b1, 32'hFFFF_FE00, hit4(i), neg_exp));
        for (int i = 0; i < 25; i++) tab.push_back(mk(2, 1'b1, 32'(i), hit5(i), i));

        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k] = 1'b0;
            in_pxl[k]   = '0;
            pos[k]      = 0;
        end
        cur.d = 0; cur.rst = 1'b1; cur.valid = 1'b0; cur.pxl = 0; cur.cnt = 0; cur.done = 1'b0;
        applyReset(2);

        $display("[TB] vector table: %0d entries", tab.size());
        foreach (tab[i]) begin
            applyStimulus(tab[i].d, tab[i].v, tab[i].p);
            cur.valid = tab[i].ev;
            cur.pxl   = tab[i].epxl;
            cur.cnt   = tab[i].ecnt;
            cur.done  = tab[i].edone;
        end

        $display("[TB] randomized frames with bubbles");
        applyReset(2);
        for (int d = 0; d < NDUT; d++) begin
            for (int f = 0; f < 3; f++) begin
                for (int k = 0; k < dim(d) * dim(d); k++) begin
                    repeat ($urandom_range(0, 2)) applyStimulus(d, 1'b0, $urandom);
                    applyStimulus(d, 1'b1, rand_pixel());
                end
            end
        end
        applyStimulus(0, 1'b0, 32'h0);

        $display("[TB] back-to-back frames");
        done_seen = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) applyStimulus(0, 1'b1, 32'(i + 100 * f));
        end
        applyStimulus(0, 1'b0, 32'h0);
        check("back-to-back frame_done pulses", done_seen, 2);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1, 32'(i + 50));
        applyReset(2);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1'b1, 32'(i));
        applyStimulus(0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
